// File: rtl/wb_retire_ctrl.sv
// wb_retire_ctrl: in-order writeback arbiter sharing one regbank write port among NREQ execution units.
module wb_retire_ctrl #(
  parameter int NREQ = 4,
  parameter int TAGW = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*TAGW-1:0] i_req_tag,
  input  logic [NREQ*5-1:0] i_req_regD,
  input  logic [NREQ*32-1:0] i_req_data,
  input  logic              i_wb_stall,
  input  logic              i_flush,
  input  logic [TAGW-1:0]   i_flush_tag,
  output logic [NREQ-1:0]   o_ack,
  output logic [31:1]       o_addrW,
  output logic [31:0]       o_wdata,
  output logic              o_ret_valid,
  output logic [TAGW-1:0]   o_ret_tag,
  output logic [TAGW-1:0]   o_exp_tag,
  output logic              o_tag_err
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [TAGW-1:0] r_exp_tag, r_ret_tag;
  logic [31:1]     r_addrW;
  logic [31:0]     r_wdata;
  logic            r_ret_valid, r_tag_err;
  logic [NREQ-1:0] w_elig;
  logic [SW-1:0]   w_sel;
  logic            w_dup, w_grant;
  logic [4:0]      w_rd;
  logic [31:0]     w_data, w_oh;
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < NREQ; k++)
      w_elig[k] = i_req[k] && (i_req_tag[k*TAGW +: TAGW] == r_exp_tag);
  end
  // Descending scan so the lowest eligible index wins
  always_comb begin
    w_sel = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_elig[k]) w_sel = SW'(k);
  end
  assign w_dup   = |(w_elig & (w_elig - 1'b1));
  assign w_grant = |w_elig && !i_wb_stall && !i_flush;
  assign w_rd    = i_req_regD[w_sel*5 +: 5];
  assign w_data  = i_req_data[w_sel*32 +: 32];
  // Index 0 lands on the dropped bit, so x0 retires without a write
  assign w_oh    = 32'(1) << w_rd;
  assign o_ack   = (w_grant && !i_reset) ? (NREQ'(1) << w_sel) : '0;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_exp_tag   <= '0;
      r_ret_tag   <= '0;
      r_addrW     <= '0;
      r_wdata     <= '0;
      r_ret_valid <= 1'b0;
      r_tag_err   <= 1'b0;
    end else begin
      r_ret_valid <= w_grant;
      r_addrW     <= w_grant ? w_oh[31:1] : '0;
      r_exp_tag   <= i_flush ? i_flush_tag : w_grant ? r_exp_tag + 1'b1 : r_exp_tag;
      r_tag_err   <= r_tag_err | w_dup;
      if (w_grant) begin
        r_ret_tag <= r_exp_tag;
        r_wdata   <= w_data;
      end
    end
  end
  assign o_addrW     = r_addrW;
  assign o_wdata     = r_wdata;
  assign o_ret_valid = r_ret_valid;
  assign o_ret_tag   = r_ret_tag;
  assign o_exp_tag   = r_exp_tag;
  assign o_tag_err   = r_tag_err;
endmodule

// File: tb/tb_wb_retire_ctrl.sv
// tb_wb_retire_ctrl: directed bench; retires are checked against a queue of expected writes.
module tb_wb_retire_ctrl;
  localparam int NREQ = 4;
  localparam int TAGW = 4;
  logic              clk, rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ*5-1:0] req_regd;
  logic [NREQ*32-1:0] req_data;
  logic              wb_stall, flush;
  logic [TAGW-1:0]   flush_tag;
  logic [NREQ-1:0]   ack;
  logic [31:1]       addrw;
  logic [31:0]       wdata;
  logic              ret_valid, tag_err;
  logic [TAGW-1:0]   ret_tag, exp_tag;
  typedef struct {logic [TAGW-1:0] tag; logic [31:1] a; logic [31:0] d;} exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  wb_retire_ctrl #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_req_tag(req_tag), .i_req_regD(req_regd),
    .i_req_data(req_data), .i_wb_stall(wb_stall), .i_flush(flush), .i_flush_tag(flush_tag),
    .o_ack(ack), .o_addrW(addrw), .o_wdata(wdata), .o_ret_valid(ret_valid),
    .o_ret_tag(ret_tag), .o_exp_tag(exp_tag), .o_tag_err(tag_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [31:1] oh(input int r);
    logic [31:1] v;
    v = '0;
    if (r != 0) v[r] = 1'b1;
    return v;
  endfunction
  task automatic set_req(input int k, input logic [3:0] t, input logic [4:0] rd, input logic [31:0] d);
    req[k] = 1'b1;
    req_tag[k*TAGW +: TAGW] = t;
    req_regd[k*5 +: 5] = rd;
    req_data[k*32 +: 32] = d;
  endtask
  task automatic expect_ret(input logic [3:0] t, input int rd, input logic [31:0] d);
    exp_t e;
    e.tag = t; e.a = oh(rd); e.d = d;
    q.push_back(e);
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic at_neg();
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (ret_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ret_tag", 64'(ret_tag), 64'(e.tag));
        chk("addrW", 64'(addrw), 64'(e.a));
        chk("wdata", 64'(wdata), 64'(e.d));
      end
    end else chk("idle_addrW", 64'(addrw), 0);
  end
  initial begin
    rst = 1'b1;
    req = '1; req_tag = '0; req_regd = {NREQ{5'd1}}; req_data = '1;
    wb_stall = 0; flush = 0; flush_tag = '0;
    at_neg(); at_neg();
    chk("rst_ack", 64'(ack), 0);
    chk("rst_exp_tag", 64'(exp_tag), 0);
    chk("rst_ret_valid", 64'(ret_valid), 0);
    chk("rst_tag_err", 64'(tag_err), 0);
    step(); req = '0;
    step(); rst = 1'b0;
    // in-order: tag1 waits behind tag0
    step(); set_req(1, 4'd1, 5'd5, 32'hAA); set_req(0, 4'd0, 5'd3, 32'h55);
    at_neg(); chk("order_ack0", 64'(ack), 64'b0001); expect_ret(0, 3, 32'h55);
    step(); req[0] = 0;
    at_neg(); chk("order_ack1", 64'(ack), 64'b0010); chk("order_exp1", 64'(exp_tag), 1); expect_ret(1, 5, 32'hAA);
    step(); req[1] = 0;
    at_neg(); chk("order_exp2", 64'(exp_tag), 2); chk("order_idle_ack", 64'(ack), 0);
    // x0 retire at tag 15 with wrap
    step(); flush = 1; flush_tag = 4'd15;
    step(); flush = 0; set_req(2, 4'd15, 5'd0, 32'h1234);
    at_neg(); chk("wrap_exp15", 64'(exp_tag), 15); chk("wrap_ack", 64'(ack), 64'b0100); expect_ret(15, 0, 32'h1234);
    step(); req[2] = 0;
    at_neg(); chk("wrap_exp0", 64'(exp_tag), 0); chk("x0_ret_valid", 64'(ret_valid), 1);
    // stall holds the eligible request off
    step(); wb_stall = 1; set_req(3, 4'd0, 5'd7, 32'h77);
    for (int i = 0; i < 3; i++) begin
      at_neg(); chk("stall_ack", 64'(ack), 0); chk("stall_exp", 64'(exp_tag), 0);
      step();
    end
    wb_stall = 0;
    at_neg(); chk("stall_release_ack", 64'(ack), 64'b1000); expect_ret(0, 7, 32'h77);
    step(); req[3] = 0;
    at_neg(); chk("stall_exp1", 64'(exp_tag), 1);
    // flush beats an eligible request
    step(); flush = 1; flush_tag = 4'd4;
    step(); flush_tag = 4'd9; set_req(0, 4'd4, 5'd4, 32'h4);
    at_neg(); chk("flush_exp4", 64'(exp_tag), 4); chk("flush_ack", 64'(ack), 0);
    step(); flush = 0; set_req(0, 4'd9, 5'd9, 32'h99);
    at_neg(); chk("flush_exp9", 64'(exp_tag), 9); chk("flush_tag9_ack", 64'(ack), 64'b0001); expect_ret(9, 9, 32'h99);
    step(); req[0] = 0;
    at_neg(); chk("flush_exp10", 64'(exp_tag), 10);
    // duplicate tags set the sticky error
    step(); flush = 1; flush_tag = 4'd0;
    step(); flush = 0; set_req(0, 4'd0, 5'd1, 32'h10); set_req(2, 4'd0, 5'd2, 32'h20);
    at_neg(); chk("dup_ack", 64'(ack), 64'b0001); chk("dup_err_before", 64'(tag_err), 0); expect_ret(0, 1, 32'h10);
    step(); req = '0;
    at_neg(); chk("dup_tag_err", 64'(tag_err), 1);
    step(); set_req(1, 4'd1, 5'd6, 32'h66);
    at_neg(); chk("clean_ack", 64'(ack), 64'b0010); expect_ret(1, 6, 32'h66);
    step(); req = '0;
    step();
    at_neg(); chk("dup_sticky", 64'(tag_err), 1); chk("clean_exp2", 64'(exp_tag), 2);
    step(); step();
    chk("queue_drained", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
